// File: rtl/tdm_demux14.sv
// rtl/tdm_demux14.sv - receive-side 4-slot TDM demultiplexer with frame and gap tracking
module tdm_demux14 #(
  parameter int WIDTH   = 4,
  parameter int GAP_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic             frame_done,
  output logic             sync_err,
  output logic [1:0]       slot
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  // Timeout fires on the idle cycle that would bring the counter to GAP_MAX.
  localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [7:0]       gap_q, gap_d;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q, sh0_d, sh1_d, sh2_d;
  logic [WIDTH-1:0] o1_q, o2_q, o3_q, o4_q, o1_d, o2_d, o3_d, o4_d;
  logic             done_q, done_d, err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      gap_q   <= 8'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      o3_q    <= '0;
      o4_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      o3_q    <= o3_d;
      o4_q    <= o4_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    o3_d    = o3_q;
    o4_d    = o4_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_start) begin
          sh0_d   = din;
          slot_d  = 2'd1;
          state_d = RUN;
        end
      end else begin
        gap_d = 8'd0;
        if (frame_start && slot_q != 2'd0) begin
          // Resynchronise on the misplaced start: this beat becomes slot 0.
          err_d  = 1'b1;
          sh0_d  = din;
          slot_d = 2'd1;
        end else begin
          case (slot_q)
            2'd0: sh0_d = din;
            2'd1: sh1_d = din;
            2'd2: sh2_d = din;
            default: begin
              o1_d   = sh0_q;
              o2_d   = sh1_q;
              o3_d   = sh2_q;
              o4_d   = din;
              done_d = 1'b1;
            end
          endcase
          slot_d = slot_q + 2'd1;
        end
      end
    end else if (state_q == RUN && slot_q != 2'd0) begin
      if (gap_q >= GAP_LAST) begin
        err_d   = 1'b1;
        state_d = HUNT;
        slot_d  = 2'd0;
        gap_d   = 8'd0;
      end else begin
        gap_d = gap_q + 8'd1;
      end
    end
  end

  always_comb begin
    out1       = o1_q;
    out2       = o2_q;
    out3       = o3_q;
    out4       = o4_q;
    frame_done = done_q;
    sync_err   = err_q;
    slot       = slot_q;
  end

endmodule

// File: doc/tdm_demux14.md
Name: tdm_demux14

Overview:
- Receive end of the 4-lane nibble mux path: the mux rotates `sel` 0..3 and places lanes in1..in4 onto one WIDTH-bit stream; this block undoes that.
- It tracks the slot position with a 2-bit slot counter and collects one frame (four beats) into shadow registers.
- It presents the whole frame on four registered outputs at once, together with a frame-done strobe and a sync-error flag.
- It sits after the mux and its TDM link, at the receive end.

Parameters:
- WIDTH, 4, bit width of each lane and of the serial beat.
- GAP_MAX, 8, maximum idle cycles allowed between beats inside a frame before the partial frame is aborted (valid range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  serial beat; belongs to the current slot.
- din_valid  input  1  din is valid this cycle.
- frame_start  input  1  qualified by din_valid; marks the beat as slot 0.
- out1  output  WIDTH  lane 0 of the last completed frame.
- out2  output  WIDTH  lane 1 of the last completed frame.
- out3  output  WIDTH  lane 2 of the last completed frame.
- out4  output  WIDTH  lane 3 of the last completed frame.
- frame_done  output  1  1-cycle pulse; out1..out4 were updated this cycle.
- sync_err  output  1  1-cycle pulse; frame aborted because of a misplaced frame_start or a gap timeout.
- slot  output  2  next expected slot (0..3).

Behaviour:
- Reset (rst=1 at a clk edge): state=HUNT, slot=0, gap counter=0, shadow regs=0, out1..out4=0, frame_done=0, sync_err=0. Reset mid-frame discards the partial frame; outputs return to 0.
- A beat is accepted only when din_valid=1. din is ignored when din_valid=0.
- HUNT:
  - Beats without frame_start are dropped and slot stays 0.
  - A beat with frame_start writes shadow[0]=din, sets slot=1 and moves to RUN.
- RUN:
  - An accepted beat without frame_start writes shadow[slot]=din, then slot=slot+1 (mod 4).
  - On the slot-3 beat, out1..out4 load {shadow0, shadow1, shadow2, din} at the same edge and frame_done=1 for that one cycle. The state stays RUN and slot wraps to 0; back-to-back frames are supported without returning to HUNT.
  - Latency: out* and frame_done are visible the cycle after the clk edge that samples the slot-3 beat.
- frame_start in RUN:
  - If slot==0, it is a normal start of a new frame; no error.
  - If slot!=0, sync_err=1 for one cycle, the partial frame is discarded (out* unchanged), and the current beat is taken as slot 0: shadow[0]=din, slot=1, state stays RUN.
- Gap timeout:
  - In RUN with slot!=0, the gap counter increments on every cycle without din_valid and clears on every accepted beat.
  - When it reaches GAP_MAX, sync_err=1 for one cycle, state=HUNT, slot=0, the partial frame is discarded and out* are unchanged.
  - With slot==0 in RUN (between frames) no timeout applies.
- Simultaneous events:
  - frame_start on the slot-3 position (slot==3) counts as a misplaced frame_start: sync_err fires and there is no frame_done.
  - frame_done and sync_err are never both asserted in the same cycle.
- out1..out4 change only on frame_done or on reset; they hold their value at all other times.
- Widths: the slot counter is 2 bits and wraps naturally; the gap counter is 8 bits and saturates at GAP_MAX.

Test Plan:
- Reset then a clean frame: rst 2 cycles; beats A,B,C,D with frame_start on A, din_valid held high -> out1..out4 = A,B,C,D one cycle after beat D; frame_done a single pulse; slot 0,1,2,3,0.
- Beats before sync: 3,5 without frame_start, then frame_start frame 1,2,3,4 -> 3 and 5 dropped; out=1,2,3,4; sync_err never asserted.
- Back-to-back frames: 1,2,3,4 then 9,8,7,6 continuous (frame_start on 1 and 9) -> frame_done 4 cycles apart; final out=9,8,7,6.
- Misplaced frame_start: frame_start on 1,2, then frame_start on E, followed by F,0,1 -> sync_err pulse at E; out unchanged until E,F,0,1 completes; out=E,F,0,1.
- Gap timeout with GAP_MAX=8: frame_start on 7, beat 8, then din_valid=0 for 8 cycles -> sync_err on the 8th idle cycle; state HUNT; out keeps its prior value; a later beat 9 without frame_start is ignored.
- Reset mid-frame: after beats A,B, assert rst one cycle -> out1..out4=0, slot=0, no frame_done; a following full frame decodes correctly.
